fetch_block_queue: RTL and testbench

Sits directly downstream of the program counter stage, between it, the instruction memory and decode. Each cycle it turns the current fetch-block PC into an in-order instruction-memory request and reserves a queue slot for the block. It buffers returned blocks, each paired with its PC, in a DEPTH-entry ring that feeds decode. It drives the PC stage's stall input. On a redirect it flushes all queued and in-flight blocks, discarding late responses by count.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_block_ring.sv | 73 +++++++
 rtl/fetch_block_queue.sv | 88 ++++++++
 tb/tb_fetch_block_queue.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch types: program counter, fetch block bundle and sizing helpers.
// The PC type and next-block helper mirror the existing PC stage header.
package fetch_pkg;

   localparam int PC_BITS           = 32;
   localparam int FETCH_BLOCK_BITS  = 128;
   localparam int FETCH_BLOCK_BYTES = FETCH_BLOCK_BITS / 8;

   typedef logic [PC_BITS-1:0] program_counter_t;

   typedef struct packed {
      program_counter_t              pc;
      logic [FETCH_BLOCK_BITS-1:0]   data;
   } fetch_block_t;

   function automatic int ptr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_bits(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic program_counter_t get_next_fetch_block_pc(
      input program_counter_t pc
   );
      return pc + program_counter_t'(FETCH_BLOCK_BYTES);
   endfunction

endpackage

// File: rtl/fetch_block_ring.sv
// Fetch block ring: PC/data storage, filled flags and alloc/fill/head pointers.
// Pointers carry one wrap bit so a completely pending ring is distinguishable.
module fetch_block_ring
   import fetch_pkg::*;
#(
   parameter  int DEPTH      = 4,
   parameter  int BLOCK_BITS = FETCH_BLOCK_BITS,
   localparam int PW         = ptr_bits(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_flush,
   input  logic                  i_alloc,
   input  program_counter_t      i_alloc_pc,
   input  logic                  i_fill,
   input  logic [BLOCK_BITS-1:0] i_fill_data,
   input  logic                  i_pop,
   output logic [PW:0]           o_pending,
   output logic                  o_head_filled,
   output program_counter_t      o_head_pc,
   output logic [BLOCK_BITS-1:0] o_head_data
);

   localparam logic [PW:0] STEP = (PW+1)'(1);

   logic [PW:0]           alloc_q, fill_q, head_q;
   logic [PW-1:0]         alloc_idx, fill_idx, head_idx;
   logic [DEPTH-1:0]      filled_q, set_m, clr_m;
   program_counter_t      pc_mem   [DEPTH];
   logic [BLOCK_BITS-1:0] data_mem [DEPTH];

   assign alloc_idx = alloc_q[PW-1:0];
   assign fill_idx  = fill_q[PW-1:0];
   assign head_idx  = head_q[PW-1:0];

   always_comb begin
      set_m = '0;
      clr_m = '0;
      if (i_alloc) clr_m[alloc_idx] = 1'b1;
      if (i_fill)  set_m[fill_idx]  = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         alloc_q  <= '0;
         fill_q   <= '0;
         head_q   <= '0;
         filled_q <= '0;
      end else if (i_flush) begin
         alloc_q  <= '0;
         fill_q   <= '0;
         head_q   <= '0;
         filled_q <= '0;
      end else begin
         if (i_alloc) alloc_q <= alloc_q + STEP;
         if (i_fill)  fill_q  <= fill_q + STEP;
         if (i_pop)   head_q  <= head_q + STEP;
         filled_q <= (filled_q & ~clr_m) | set_m;
      end
   end

   // Payload storage is deliberately left unreset.
   always_ff @(posedge i_clk) begin
      if (i_alloc) pc_mem[alloc_idx]  <= i_alloc_pc;
      if (i_fill)  data_mem[fill_idx] <= i_fill_data;
   end

   assign o_pending     = alloc_q - fill_q;
   assign o_head_filled = filled_q[head_idx];
   assign o_head_pc     = pc_mem[head_idx];
   assign o_head_data   = data_mem[head_idx];

endmodule

// File: rtl/fetch_block_queue.sv
// Fetch block queue: issues in-order block requests, buffers responses for
// decode and discards late responses by count after a redirect.
module fetch_block_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int BLOCK_BITS = FETCH_BLOCK_BITS
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  program_counter_t      i_pc,
   input  logic                  i_flush,
   output logic                  o_stall,
   output logic                  o_req_valid,
   output program_counter_t      o_req_pc,
   input  logic                  i_req_ready,
   input  logic                  i_resp_valid,
   input  logic [BLOCK_BITS-1:0] i_resp_data,
   output logic                  o_fb_valid,
   output program_counter_t      o_fb_pc,
   output logic [BLOCK_BITS-1:0] o_fb_data,
   input  logic                  i_fb_ready
);

   localparam int            CW    = cnt_bits(DEPTH);
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW:0]   LIMIT = (CW+1)'(DEPTH);

   logic [CW-1:0] used_q, drop_q, pending;
   logic [CW-1:0] drop_total, drop_flush;
   logic [CW:0]   credit;
   logic          accept, pop, head_filled;
   logic          resp_fill, resp_drop;

   assign credit      = {1'b0, used_q} + {1'b0, drop_q};
   assign o_req_valid = i_rst_n & ~i_flush & (credit < LIMIT);
   assign accept      = o_req_valid & i_req_ready;
   assign o_stall     = ~accept;
   assign o_req_pc    = i_pc;

   assign resp_drop = i_resp_valid & (drop_q != '0);
   assign resp_fill = i_resp_valid & (drop_q == '0)
                    & (pending != '0) & ~i_flush;

   assign o_fb_valid = (used_q != '0) & head_filled;
   assign pop        = o_fb_valid & i_fb_ready;

   // All in-flight requests become drops; a flush-cycle response is one of them.
   assign drop_total = drop_q + pending;
   assign drop_flush = (i_resp_valid && drop_total != '0)
                     ? drop_total - ONE : drop_total;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         used_q <= '0;
         drop_q <= '0;
      end else if (i_flush) begin
         used_q <= '0;
         drop_q <= drop_flush;
      end else begin
         unique case ({accept, pop})
            2'b10:   used_q <= used_q + ONE;
            2'b01:   used_q <= used_q - ONE;
            default: ;
         endcase
         if (resp_drop) drop_q <= drop_q - ONE;
      end
   end

   fetch_block_ring #(
      .DEPTH      (DEPTH),
      .BLOCK_BITS (BLOCK_BITS)
   ) u_ring (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_flush       (i_flush),
      .i_alloc       (accept),
      .i_alloc_pc    (i_pc),
      .i_fill        (resp_fill),
      .i_fill_data   (i_resp_data),
      .i_pop         (pop),
      .o_pending     (pending),
      .o_head_filled (head_filled),
      .o_head_pc     (o_fb_pc),
      .o_head_data   (o_fb_data)
   );

endmodule

// File: tb/tb_fetch_block_queue.sv
// Bench for fetch_block_queue: in-order memory and decode model with
// per-epoch scoreboard of requested PCs.
module tb_fetch_block_queue;
   import fetch_pkg::*;

   localparam int DEPTH = 4;
   localparam int BB    = 128;
   localparam program_counter_t INIT_PC = 32'h8000_0000;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   program_counter_t i_pc, o_req_pc, o_fb_pc;
   logic             i_flush, o_stall, o_req_valid, i_req_ready;
   logic             i_resp_valid, o_fb_valid, i_fb_ready;
   logic [BB-1:0]    i_resp_data, o_fb_data;

   always #5 clk = ~clk;

   fetch_block_queue #(.DEPTH(DEPTH), .BLOCK_BITS(BB)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_pc         (i_pc),
      .i_flush      (i_flush),
      .o_stall      (o_stall),
      .o_req_valid  (o_req_valid),
      .o_req_pc     (o_req_pc),
      .i_req_ready  (i_req_ready),
      .i_resp_valid (i_resp_valid),
      .i_resp_data  (i_resp_data),
      .o_fb_valid   (o_fb_valid),
      .o_fb_pc      (o_fb_pc),
      .o_fb_data    (o_fb_data),
      .i_fb_ready   (i_fb_ready)
   );

   typedef struct {
      program_counter_t pc;
      int               epoch;
      int               due;
   } mreq_t;

   mreq_t            mem_q[$];
   program_counter_t cur_q[$];
   program_counter_t pc_next, e_fbpc, f_tgt;
   int               n_filled, epoch, cyc, lat_lo, lat_hi;
   int               vectors, errors;
   logic             e_rv, e_fbv, acc, pop, rsp, f_now;

   function automatic logic [BB-1:0] blk(input program_counter_t p);
      return {p, ~p, p ^ 32'hA5A5_5A5A, p + 32'd1};
   endfunction

   task automatic model_reset();
      mem_q.delete();
      cur_q.delete();
      n_filled = 0;
      epoch++;
      pc_next = INIT_PC;
      acc = 0; pop = 0; rsp = 0; f_now = 0;
   endtask

   task automatic do_reset();
      i_flush = 0; i_req_ready = 0; i_resp_valid = 0; i_fb_ready = 0;
      rst_n = 0;
      model_reset();
      i_pc = INIT_PC;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   // Drive one cycle at the falling edge and predict outputs from the model.
   task automatic step(input logic f, input program_counter_t tgt,
                       input logic rdy, input logic want, input logic fbr);
      int stale;
      stale = 0;
      @(negedge clk);
      foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
      rsp = want && mem_q.size() > 0 && mem_q[0].due <= cyc;
      i_pc = pc_next;
      i_flush = f;
      i_req_ready = rdy;
      i_fb_ready = fbr;
      i_resp_valid = rsp;
      i_resp_data = rsp ? blk(mem_q[0].pc)
                        : {$urandom, $urandom, $urandom, $urandom};
      e_rv = !f && (cur_q.size() + stale < DEPTH);
      acc = e_rv && rdy;
      e_fbv = n_filled > 0;
      e_fbpc = (cur_q.size() > 0) ? cur_q[0] : '0;
      pop = e_fbv && fbr;
      f_now = f;
      f_tgt = tgt;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (pop) begin
         void'(cur_q.pop_front());
         n_filled--;
      end
      if (rsp) begin
         mreq_t m;
         m = mem_q.pop_front();
         if (m.epoch == epoch) n_filled++;
      end
      if (acc) begin
         int lat;
         lat = $urandom_range(lat_hi, lat_lo);
         mem_q.push_back('{pc: i_pc, epoch: epoch, due: cyc + lat});
         cur_q.push_back(i_pc);
         pc_next = get_next_fetch_block_pc(i_pc);
      end
      if (f_now) begin
         epoch++;
         cur_q.delete();
         n_filled = 0;
         pc_next = f_tgt;
      end
      cyc++;
   endtask

   task automatic test_reset();
      i_flush = 0; i_req_ready = 1; i_resp_valid = 0; i_fb_ready = 1;
      i_resp_data = '0; i_pc = INIT_PC;
      #1 rst_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      vectors += 4;
      if (o_req_valid !== 1'b0) begin
         errors++; $display("FAIL reset_req_valid got %b exp 0", o_req_valid);
      end
      if (o_stall !== 1'b1) begin
         errors++; $display("FAIL reset_stall got %b exp 1", o_stall);
      end
      if (o_fb_valid !== 1'b0) begin
         errors++; $display("FAIL reset_fb_valid got %b exp 0", o_fb_valid);
      end
      if (o_req_pc !== i_pc) begin
         errors++; $display("FAIL reset_req_pc got %h exp %h", o_req_pc, i_pc);
      end
      i_req_ready = 0;
      rst_n = 1;
      #1;
      vectors++;
      if (o_req_valid !== 1'b1) begin
         errors++; $display("FAIL release_req_valid got %b exp 1", o_req_valid);
      end
   endtask

   task automatic test_stream();
      int k;
      k = 0;
      lat_lo = 1; lat_hi = 1;
      for (int c = 0; c < 24; c++) begin
         step(0, '0, 1, 1, 1);
         vectors += 2;
         if (o_stall !== 1'b0) begin
            errors++; $display("FAIL stream_stall c=%0d got %b exp 0", c, o_stall);
         end
         if (o_fb_valid !== e_fbv) begin
            errors++;
            $display("FAIL stream_fb_valid c=%0d got %b exp %b", c, o_fb_valid, e_fbv);
         end
         if (e_fbv) begin
            vectors++;
            if (o_fb_pc !== INIT_PC + 32'(16 * k)) begin
               errors++;
               $display("FAIL stream_fb_pc got %h exp %h", o_fb_pc, INIT_PC + 32'(16 * k));
            end
            k++;
         end
         tick();
      end
   endtask

   task automatic test_full();
      int n_acc;
      n_acc = 0;
      do_reset();
      lat_lo = 1; lat_hi = 1;
      for (int c = 0; c < 8; c++) begin
         step(0, '0, 1, 1, 0);
         if (!o_stall) n_acc++;
         vectors++;
         if (o_req_valid !== e_rv) begin
            errors++;
            $display("FAIL full_req_valid c=%0d got %b exp %b", c, o_req_valid, e_rv);
         end
         tick();
      end
      vectors++;
      if (n_acc != DEPTH) begin
         errors++; $display("FAIL full_accepts got %0d exp %0d", n_acc, DEPTH);
      end
      step(0, '0, 1, 1, 1);
      vectors += 2;
      if (o_fb_valid !== 1'b1) begin
         errors++; $display("FAIL full_pop_valid got %b exp 1", o_fb_valid);
      end
      if (o_req_valid !== 1'b0) begin
         errors++; $display("FAIL full_pop_req got %b exp 0", o_req_valid);
      end
      tick();
      step(0, '0, 1, 1, 0);
      vectors++;
      if (o_req_valid !== 1'b1) begin
         errors++; $display("FAIL full_reissue got %b exp 1", o_req_valid);
      end
      if (!o_stall) n_acc++;
      tick();
      for (int c = 0; c < 4; c++) begin
         step(0, '0, 1, 1, 0);
         if (!o_stall) n_acc++;
         tick();
      end
      vectors++;
      if (n_acc != DEPTH + 1) begin
         errors++; $display("FAIL full_after_pop got %0d exp %0d", n_acc, DEPTH + 1);
      end
   endtask

   task automatic test_flush_drop();
      int budget;
      logic got;
      do_reset();
      lat_lo = 5; lat_hi = 5;
      for (int c = 0; c < 3; c++) begin
         step(0, '0, 1, 0, 1);
         tick();
      end
      budget = 0;
      while (mem_q.size() > 0 && mem_q[0].due > cyc && budget < 20) begin
         step(0, '0, 0, 1, 1);
         tick();
         budget++;
      end
      step(1, 32'h9000_0000, 0, 1, 1);
      vectors++;
      if (o_req_valid !== 1'b0 || o_stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_req got v=%b s=%b exp v=0 s=1", o_req_valid, o_stall);
      end
      tick();
      lat_lo = 1; lat_hi = 1;
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         step(0, '0, 1, 1, 1);
         vectors++;
         if (o_fb_valid !== e_fbv) begin
            errors++;
            $display("FAIL drop_fb_valid c=%0d got %b exp %b", c, o_fb_valid, e_fbv);
         end
         if (e_fbv) begin
            got = 1;
            vectors++;
            if (o_fb_pc !== 32'h9000_0000) begin
               errors++; $display("FAIL drop_first_pc got %h exp 90000000", o_fb_pc);
            end
         end
         tick();
      end
      vectors++;
      if (!got) begin
         errors++; $display("FAIL drop_timeout got none exp delivery");
      end
   endtask

   task automatic test_flush_credit();
      do_reset();
      lat_lo = 8; lat_hi = 8;
      for (int c = 0; c < 3; c++) begin
         step(0, '0, 1, 0, 1);
         tick();
      end
      step(1, 32'hA000_0000, 0, 0, 1);
      tick();
      lat_lo = 1; lat_hi = 1;
      step(0, '0, 1, 1, 1);
      vectors++;
      if (o_req_valid !== 1'b1) begin
         errors++; $display("FAIL credit_first got %b exp 1", o_req_valid);
      end
      tick();
      step(0, '0, 1, 1, 1);
      vectors++;
      if (o_req_valid !== 1'b0 || o_stall !== 1'b1) begin
         errors++;
         $display("FAIL credit_limit got v=%b s=%b exp v=0 s=1", o_req_valid, o_stall);
      end
      tick();
      for (int c = 0; c < 20; c++) begin
         step(0, '0, 1, 1, 1);
         vectors += 2;
         if (o_req_valid !== e_rv) begin
            errors++;
            $display("FAIL credit_req c=%0d got %b exp %b", c, o_req_valid, e_rv);
         end
         if (o_fb_valid !== e_fbv) begin
            errors++;
            $display("FAIL credit_fb c=%0d got %b exp %b", c, o_fb_valid, e_fbv);
         end
         if (e_fbv) begin
            vectors++;
            if (o_fb_pc !== e_fbpc) begin
               errors++; $display("FAIL credit_pc got %h exp %h", o_fb_pc, e_fbpc);
            end
         end
         tick();
      end
   endtask

   task automatic test_random();
      do_reset();
      lat_lo = 1; lat_hi = 4;
      for (int c = 0; c < 10000; c++) begin
         logic f;
         program_counter_t t;
         f = ($urandom_range(99) < 3);
         t = $urandom & 32'hFFFF_FFF0;
         step(f, t, $urandom_range(3) != 0, $urandom_range(3) != 0,
              $urandom_range(2) != 0);
         vectors += 4;
         if (o_req_valid !== e_rv) begin
            errors++;
            $display("FAIL rand_req_valid c=%0d got %b exp %b", c, o_req_valid, e_rv);
         end
         if (o_stall !== !acc) begin
            errors++; $display("FAIL rand_stall c=%0d got %b exp %b", c, o_stall, !acc);
         end
         if (o_req_pc !== i_pc) begin
            errors++; $display("FAIL rand_req_pc c=%0d got %h exp %h", c, o_req_pc, i_pc);
         end
         if (o_fb_valid !== e_fbv) begin
            errors++;
            $display("FAIL rand_fb_valid c=%0d got %b exp %b", c, o_fb_valid, e_fbv);
         end
         if (e_fbv) begin
            vectors += 2;
            if (o_fb_pc !== e_fbpc) begin
               errors++; $display("FAIL rand_fb_pc c=%0d got %h exp %h", c, o_fb_pc, e_fbpc);
            end
            if (o_fb_data !== blk(e_fbpc)) begin
               errors++;
               $display("FAIL rand_fb_data c=%0d got %h exp %h", c, o_fb_data, blk(e_fbpc));
            end
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      logic got;
      do_reset();
      lat_lo = 2; lat_hi = 2;
      for (int c = 0; c < 4; c++) begin
         step(0, '0, 1, 1, 0);
         tick();
      end
      #2;
      vectors++;
      if (o_fb_valid !== 1'b1) begin
         errors++; $display("FAIL arst_pre_valid got %b exp 1", o_fb_valid);
      end
      rst_n = 0;
      #1;
      vectors += 3;
      if (o_fb_valid !== 1'b0) begin
         errors++; $display("FAIL arst_fb_valid got %b exp 0", o_fb_valid);
      end
      if (o_req_valid !== 1'b0) begin
         errors++; $display("FAIL arst_req_valid got %b exp 0", o_req_valid);
      end
      if (o_stall !== 1'b1) begin
         errors++; $display("FAIL arst_stall got %b exp 1", o_stall);
      end
      do_reset();
      lat_lo = 1; lat_hi = 1;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         step(0, '0, 1, 1, 1);
         vectors++;
         if (o_fb_valid !== e_fbv) begin
            errors++;
            $display("FAIL arst_restart_valid c=%0d got %b exp %b", c, o_fb_valid, e_fbv);
         end
         if (e_fbv && !got) begin
            got = 1;
            vectors++;
            if (o_fb_pc !== INIT_PC) begin
               errors++; $display("FAIL arst_first_pc got %h exp %h", o_fb_pc, INIT_PC);
            end
         end
         tick();
      end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      epoch   = 0;
      cyc     = 0;
      lat_lo  = 1;
      lat_hi  = 1;
      test_reset();
      test_stream();
      test_full();
      test_flush_drop();
      test_flush_credit();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
